// File: rtl/spcore_seq_pkg.sv
// Shared constants for the self-sequencing streaming-processor core:
// 4-bit opcode encodings, FSM state encoding and small opcode helpers.
package spcore_seq_pkg;

  localparam int OP_W = 4;
  typedef logic [OP_W-1:0] opcode_t;

  localparam opcode_t OP_CLEAR   = 4'd0;
  localparam opcode_t OP_LOADI   = 4'd1;
  localparam opcode_t OP_ADD     = 4'd2;
  localparam opcode_t OP_SUB     = 4'd3;
  localparam opcode_t OP_MUL     = 4'd4;
  localparam opcode_t OP_MAD     = 4'd5;
  localparam opcode_t OP_CORE_ID = 4'd6;
  localparam opcode_t OP_N_CORES = 4'd7;
  localparam opcode_t OP_LOAD    = 4'd8;
  localparam opcode_t OP_STORE   = 4'd9;
  // Encodings 10..15 are undefined and retire as NOP.

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_EXEC = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4
  } state_t;

  // Opcodes that write R[rx] in WB (and therefore update P).
  function automatic logic op_writes_reg(input opcode_t op);
    case (op)
      OP_CLEAR, OP_LOADI, OP_ADD, OP_SUB, OP_MUL, OP_MAD,
      OP_CORE_ID, OP_N_CORES, OP_LOAD: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

  // Opcodes that pass through the MEM state.
  function automatic logic op_is_mem(input opcode_t op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/spcore_regfile.sv
// Register file: NREGS x DATA_W, three asynchronous read ports,
// one synchronous write port, asynchronous reset of every entry to 0.
module spcore_regfile #(
  parameter int  DATA_W = 16,
  parameter int  NREGS  = 16,
  localparam int RA_W   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [RA_W-1:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RA_W-1:0]   raddr_a,
  input  logic [RA_W-1:0]   raddr_b,
  input  logic [RA_W-1:0]   raddr_c,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] regs [NREGS];

  // Register storage with single write port.
  // NOTE: every entry is cleared on reset because the core's reset contract
  // says all registers read 0; this forces flops rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
  assign rdata_c = regs[raddr_c];

endmodule

// File: rtl/spcore_seq.sv
// Self-sequencing streaming-processor core. Accepts one decoded instruction
// per valid/ready handshake and walks IDLE -> READ -> EXEC -> (MEM) -> WB.
// Optional build macro: SPCORE_SAT_EN (saturating ADD/MUL/MAD/SUB).
module spcore_seq
  import spcore_seq_pkg::*;
#(
  parameter int  DATA_W  = 16,
  parameter int  NREGS   = 16,
  parameter int  CORE_ID = 0,
  parameter int  N_CORES = 1,
  localparam int RA_W    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   op,
  input  logic [RA_W-1:0]   rx,
  input  logic [RA_W-1:0]   ry,
  input  logic [RA_W-1:0]   rz,
  input  logic [DATA_W-1:0] imm,
  output logic              done,
  output logic              P,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam logic [DATA_W-1:0] CORE_ID_V = DATA_W'(CORE_ID);
  localparam logic [DATA_W-1:0] N_CORES_V = DATA_W'(N_CORES);

  state_t            state_q, state_d;
  opcode_t           op_q;
  logic [RA_W-1:0]   rx_q, ry_q, rz_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] x_q, y_q, z_q;      // operands R[rx], R[ry], R[rz]
  logic [DATA_W-1:0] res_q, alu_res;
  logic              p_q;
  logic [DATA_W-1:0] rd_x, rd_y, rd_z;
  logic              rf_we;

  spcore_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (rf_we),
    .waddr   (rx_q),
    .wdata   (res_q),
    .raddr_a (rx_q),
    .raddr_b (ry_q),
    .raddr_c (rz_q),
    .rdata_a (rd_x),
    .rdata_b (rd_y),
    .rdata_c (rd_z)
  );

  // FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake/memory outputs; en low freezes and masks pulses.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    mem_req     = (state_q == ST_MEM);
    mem_we      = (state_q == ST_MEM) && (op_q == OP_STORE);
    rf_we       = 1'b0;
    if (en) begin
      case (state_q)
        ST_IDLE: begin
          instr_ready = 1'b1;
          if (instr_valid) state_d = ST_READ;
        end
        ST_READ: state_d = ST_EXEC;
        ST_EXEC: state_d = op_is_mem(op_q) ? ST_MEM : ST_WB;
        ST_MEM: begin
          if (mem_ack) begin
            if (op_q == OP_STORE) begin
              done    = 1'b1;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_WB;
            end
          end
        end
        ST_WB: begin
          done    = 1'b1;
          rf_we   = op_writes_reg(op_q);
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Result computation from the latched operands.
`ifdef SPCORE_SAT_EN
  localparam int PW = 2 * DATA_W;
  logic [DATA_W:0]   sum_w;
  logic [PW-1:0]     prod_w;
  logic [PW:0]       mad_w;
`endif

  always_comb begin
    alu_res = '0;
`ifdef SPCORE_SAT_EN
    sum_w  = {1'b0, y_q} + {1'b0, z_q};
    prod_w = PW'(y_q) * PW'(z_q);
    mad_w  = (PW + 1)'(x_q) + {1'b0, prod_w};
`endif
    case (op_q)
      OP_CLEAR:   alu_res = '0;
      OP_LOADI:   alu_res = imm_q;
`ifdef SPCORE_SAT_EN
      OP_ADD:     alu_res = sum_w[DATA_W] ? '1 : sum_w[DATA_W-1:0];
      OP_SUB:     alu_res = (y_q < z_q) ? '0 : y_q - z_q;
      OP_MUL:     alu_res = (|prod_w[PW-1:DATA_W]) ? '1 : prod_w[DATA_W-1:0];
      OP_MAD:     alu_res = (|mad_w[PW:DATA_W]) ? '1 : mad_w[DATA_W-1:0];
`else
      OP_ADD:     alu_res = y_q + z_q;
      OP_SUB:     alu_res = y_q - z_q;
      OP_MUL:     alu_res = y_q * z_q;
      OP_MAD:     alu_res = x_q + y_q * z_q;
`endif
      OP_CORE_ID: alu_res = CORE_ID_V;
      OP_N_CORES: alu_res = N_CORES_V;
      default:    alu_res = '0;
    endcase
  end

  // Instruction latch, operand read, result capture and predicate update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= OP_CLEAR;
      rx_q  <= '0;
      ry_q  <= '0;
      rz_q  <= '0;
      imm_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      z_q   <= '0;
      res_q <= '0;
      p_q   <= 1'b0;
    end else if (en) begin
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            op_q  <= op;
            rx_q  <= rx;
            ry_q  <= ry;
            rz_q  <= rz;
            imm_q <= imm;
          end
        end
        ST_READ: begin
          x_q <= rd_x;
          y_q <= rd_y;
          z_q <= rd_z;
        end
        ST_EXEC: res_q <= alu_res;
        ST_MEM:  if (mem_ack && (op_q == OP_LOAD)) res_q <= mem_rdata;
        ST_WB:   if (op_writes_reg(op_q)) p_q <= (res_q == '0);
        default: ;
      endcase
    end
  end

  assign P         = p_q;
  assign mem_addr  = y_q;
  assign mem_wdata = x_q;

endmodule

// File: tb/tb_spcore_seq.sv
// Self-checking bench for spcore_seq: directed test-plan sequence, then
// randomized instructions, all compared cycle by cycle against a
// behavioural register/memory model.
module tb_spcore_seq;

`ifdef SPCORE_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, en, instr_valid, instr_ready;
  logic [3:0]  op, rx, ry, rz;
  logic [15:0] imm;
  logic        done, P, mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  spcore_seq #(
    .DATA_W  (16),
    .NREGS   (16),
    .CORE_ID (100),
    .N_CORES (200)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .op          (op),
    .rx          (rx),
    .ry          (ry),
    .rz          (rz),
    .imm         (imm),
    .done        (done),
    .P           (P),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state and per-cycle expectations.
  logic [15:0] model_r [16];
  logic        model_p;
  logic [15:0] model_mem [logic [15:0]];
  logic        exp_ready, exp_done, exp_req, exp_we;
  logic [15:0] exp_addr, exp_wdata;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: DUT outputs against model expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      check("done", {31'd0, done}, {31'd0, exp_done});
      check("instr_ready", {31'd0, instr_ready}, {31'd0, exp_ready});
      check("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
      check("P", {31'd0, P}, {31'd0, model_p});
      if (exp_req) begin
        check("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        check("mem_addr", {16'd0, mem_addr}, {16'd0, exp_addr});
        check("mem_wdata", {16'd0, mem_wdata}, {16'd0, exp_wdata});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] sat_or_wrap(input longint s);
    if (SAT && s > 65535) return 16'hFFFF;
    if (SAT && s < 0)     return 16'h0000;
    return 16'(s);
  endfunction

  // Opcode semantics at the arithmetic level.
  function automatic void alu_model(input logic [3:0] opc, input logic [15:0] xv, yv, zv, iv,
                                    output logic wr, output logic [15:0] v);
    wr = 1'b1;
    v  = 16'h0;
    case (opc)
      4'd0: v = 16'h0;
      4'd1: v = iv;
      4'd2: v = sat_or_wrap(longint'(yv) + longint'(zv));
      4'd3: v = sat_or_wrap(longint'(yv) - longint'(zv));
      4'd4: v = sat_or_wrap(longint'(yv) * longint'(zv));
      4'd5: v = sat_or_wrap(longint'(xv) + longint'(yv) * longint'(zv));
      4'd6: v = 16'd100;
      4'd7: v = 16'd200;
      default: wr = 1'b0;
    endcase
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      instr_valid = 1'b0;
      exp_ready   = 1'b1;
      exp_done    = 1'b0;
      step();
    end
  endtask

  // Handshake cycle plus the two cycles before retire/memory.
  task automatic fetch(input logic [3:0] opc, input logic [3:0] x, y, z, input logic [15:0] iv);
    instr_valid = 1'b1;
    op = opc; rx = x; ry = y; rz = z; imm = iv;
    exp_ready = 1'b1;
    exp_done  = 1'b0;
    step();
    instr_valid = 1'b0;
    op  = 4'($urandom_range(0, 15));
    rx  = 4'($urandom_range(0, 15));
    ry  = 4'($urandom_range(0, 15));
    rz  = 4'($urandom_range(0, 15));
    imm = 16'($urandom);
    exp_ready = 1'b0;
    step();
    step();
  endtask

  task automatic alu_instr(input logic [3:0] opc, input logic [3:0] x, y, z, input logic [15:0] iv);
    logic        wr;
    logic [15:0] v;
    alu_model(opc, model_r[x], model_r[y], model_r[z], iv, wr, v);
    fetch(opc, x, y, z, iv);
    exp_done = 1'b1;
    step();
    exp_done  = 1'b0;
    exp_ready = 1'b1;
    if (wr) begin
      model_r[x] = v;
      model_p    = (v == 16'h0);
    end
  endtask

  // LOAD/STORE: ack raised after ack_delay MEM cycles and held; en dropped for
  // pause_len cycles starting at MEM cycle pause_at.
  task automatic mem_op(input logic st, input logic [3:0] x, y, input int ack_delay,
                        input int pause_at, input int pause_len,
                        output logic [15:0] seen_addr, output logic [15:0] seen_wdata);
    logic [15:0] a, wd, rd;
    bit          fin;
    a  = model_r[y];
    wd = model_r[x];
    rd = model_mem.exists(a) ? model_mem[a] : 16'($urandom);
    fetch(st ? 4'd9 : 4'd8, x, y, 4'($urandom_range(0, 15)), 16'($urandom));
    seen_addr  = mem_addr;
    seen_wdata = mem_wdata;
    exp_req = 1'b1; exp_we = st; exp_addr = a; exp_wdata = wd;
    fin = 1'b0;
    for (int i = 0; i < 64 && !fin; i++) begin
      en        = !(i >= pause_at && i < pause_at + pause_len);
      mem_ack   = (i >= ack_delay);
      mem_rdata = mem_ack ? rd : 16'($urandom);
      exp_done  = st && en && mem_ack;
      fin       = en && mem_ack;
      step();
    end
    if (!fin) check("mem_op_bound", 32'd0, 32'd1);
    en = 1'b1; mem_ack = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
    exp_done = 1'b0;
    if (!st) begin
      exp_done = 1'b1;
      step();
      exp_done   = 1'b0;
      model_r[x] = rd;
      model_p    = (rd == 16'h0);
    end else begin
      model_mem[a] = wd;
    end
    exp_ready = 1'b1;
  endtask

  logic [15:0] sa, sw;

  initial begin
    reset = 1'b1; en = 1'b1; instr_valid = 1'b0;
    op = '0; rx = '0; ry = '0; rz = '0; imm = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    for (int i = 0; i < 16; i++) model_r[i] = 16'h0;
    model_p = 1'b0;
    exp_ready = 1'b1; exp_done = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
    exp_addr = '0; exp_wdata = '0;
    step();
    step();
    check("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_P", {31'd0, P}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    reset = 1'b0;
    chk_en = 1'b1;
    idle(1);

    // Directed test-plan sequence.
    alu_instr(4'd1, 4'd0, 4'd0, 4'd0, 16'd11);
    alu_instr(4'd1, 4'd1, 4'd0, 4'd0, 16'd20);
    alu_instr(4'd2, 4'd2, 4'd0, 4'd1, 16'd0);
    check("lit_add_P", {31'd0, P}, 32'd0);
    mem_op(1'b1, 4'd2, 4'd0, 3, 99, 0, sa, sw);
    check("lit_add_R2", {16'd0, sw}, 32'd31);
    check("lit_store_addr", {16'd0, sa}, 32'd11);
    alu_instr(4'd5, 4'd2, 4'd0, 4'd1, 16'd0);
    mem_op(1'b1, 4'd2, 4'd0, 0, 99, 0, sa, sw);
    check("lit_mad_R2", {16'd0, sw}, 32'd251);
    alu_instr(4'd4, 4'd2, 4'd0, 4'd1, 16'd0);
    alu_instr(4'd3, 4'd3, 4'd0, 4'd1, 16'd0);
    mem_op(1'b1, 4'd3, 4'd0, 1, 99, 0, sa, sw);
    check("lit_sub_R3", {16'd0, sw}, SAT ? 32'd0 : 32'hFFF7);
    alu_instr(4'd6, 4'd3, 4'd0, 4'd0, 16'd0);
    mem_op(1'b1, 4'd3, 4'd0, 0, 99, 0, sa, sw);
    check("lit_core_id", {16'd0, sw}, 32'd100);
    alu_instr(4'd7, 4'd3, 4'd0, 4'd0, 16'd0);
    mem_op(1'b1, 4'd3, 4'd0, 0, 99, 0, sa, sw);
    check("lit_n_cores", {16'd0, sw}, 32'd200);
    alu_instr(4'd1, 4'd4, 4'd0, 4'd0, 16'hFFFF);
    alu_instr(4'd1, 4'd5, 4'd0, 4'd0, 16'd1);
    alu_instr(4'd2, 4'd6, 4'd4, 4'd5, 16'd0);
    check("lit_ovf_P", {31'd0, P}, SAT ? 32'd0 : 32'd1);
    mem_op(1'b1, 4'd6, 4'd0, 0, 99, 0, sa, sw);
    check("lit_ovf_R6", {16'd0, sw}, SAT ? 32'hFFFF : 32'd0);
    // STORE R2 (MUL result) then LOAD it back with a 2-cycle en pause in MEM.
    mem_op(1'b1, 4'd2, 4'd0, 3, 99, 0, sa, sw);
    check("lit_mul_R2", {16'd0, sw}, 32'd220);
    mem_op(1'b0, 4'd7, 4'd0, 3, 1, 2, sa, sw);
    mem_op(1'b1, 4'd7, 4'd0, 0, 99, 0, sa, sw);
    check("lit_load_R7", {16'd0, sw}, 32'd220);
    // Undefined opcode retires without a write.
    alu_instr(4'd12, 4'd7, 4'd0, 4'd0, 16'h5555);
    idle(2);

    // Randomized instruction stream.
    for (int n = 0; n < 120; n++) begin
      logic [3:0]  opc, x, y, z;
      logic [15:0] iv;
      int          k;
      opc = 4'($urandom_range(0, 15));
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      z = 4'($urandom_range(0, 15));
      k = $urandom_range(0, 3);
      iv = (k == 0) ? 16'hFFFF : (k == 1) ? 16'h0000 : 16'($urandom);
      if (n % 7 == 0) begin
        y = x; z = x;
      end
      if (opc == 4'd8 || opc == 4'd9)
        mem_op(opc == 4'd9, x, y, $urandom_range(0, 3), $urandom_range(0, 4),
               $urandom_range(0, 2), sa, sw);
      else
        alu_instr(opc, x, y, z, iv);
      idle($urandom_range(0, 2));
    end

    // Reset in the MEM state of a LOAD.
    fetch(4'd8, 4'd7, 4'd0, 4'd0, 16'd0);
    check("rst_mid_req_before", {31'd0, mem_req}, 32'd1);
    chk_en = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 16'h1234;
    #2 reset = 1'b1;
    #1;
    check("rst_mid_req_async", {31'd0, mem_req}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_mid_done_hold", {31'd0, done}, 32'd0);
    mem_ack = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 16; i++) model_r[i] = 16'h0;
    model_p = 1'b0;
    exp_ready = 1'b1; exp_done = 1'b0; exp_req = 1'b0; exp_we = 1'b0;
    #1;
    check("rst_mid_ready", {31'd0, instr_ready}, 32'd1);
    chk_en = 1'b1;
    idle(2);
    mem_op(1'b1, 4'd7, 4'd0, 1, 99, 0, sa, sw);
    check("rst_mid_R7", {16'd0, sw}, 32'd0);
    check("rst_mid_addr", {16'd0, sa}, 32'd0);
    idle(2);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
